dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, meaning storage holds 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states per access, legal range 0..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store word, 0 = load word.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  initiator takes the response.
REQ-012 SHALL have port resp_rdata  output  32  load data; 32'h0 for stores.
REQ-013 SHALL have port resp_err  output  1  access error flag.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; all outputs SHALL be registered.
REQ-015 SHALL drive req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-016 SHALL accept a request at a rising edge with req_valid&&req_ready, latching req_we, req_addr, req_wdata; inputs after accept are ignored.
REQ-017 SHALL on accept load the wait counter with WAIT_CYCLES and go to WAIT, or directly to RESP when WAIT_CYCLES=0.
REQ-018 SHALL in WAIT decrement the counter each edge and enter RESP on the edge where it reaches 0; resp_valid rises exactly WAIT_CYCLES+1 cycles after the accept cycle.
REQ-019 SHALL perform the memory access on the edge entering RESP: store commits the word; load captures the word into resp_rdata.
REQ-020 SHALL index storage with req_addr[DEPTH_LOG2+1:2]; upper address bits ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
REQ-021 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until the edge with resp_valid&&resp_ready, then go to IDLE with resp_valid=0.
REQ-022 SHALL accept no new request in the handshake cycle; earliest next accept is the following cycle (one outstanding transaction max).
REQ-023 SHALL ignore req_valid pulses withdrawn before acceptance.
REQ-024 SHALL return a load issued after a store to the same word with the newly stored value.

Reset
REQ-025 SHALL on rst low immediately force state IDLE, req_ready=0, resp_valid=0, resp_rdata=32'h0, resp_err=0, counter=0.
REQ-026 SHALL set req_ready=1 on the first rising edge after rst deasserts; no request is accepted on that edge.
REQ-027 SHALL abandon an in-flight transaction on reset; a store not yet committed per REQ-019 SHALL NOT be written.
REQ-028 SHALL NOT clear storage contents on reset.

Configuration
REQ-029 SHALL, with macro DM_RESP_ALIGN_CHK_EN defined, flag any request with req_addr[1:0]!=2'b00: resp_err=1, store suppressed, resp_rdata=32'h0, same latency.
REQ-030 SHALL, without DM_RESP_ALIGN_CHK_EN, ignore req_addr[1:0] and hold resp_err at 0.

Verification
REQ-031 SHALL cover: WAIT_CYCLES=2, store 32'hDEADBEEF to addr 32'h10, then load 32'h10 -> resp_rdata=32'hDEADBEEF, resp_valid rises 3 cycles after each accept, resp_err=0.
REQ-032 SHALL cover: WAIT_CYCLES=0, load accepted -> resp_valid high the next cycle; resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready=0 throughout.
REQ-033 SHALL cover: DEPTH_LOG2=6, store 32'h12345678 to 32'h0, load 32'h100 -> 32'h12345678 (alias).
REQ-034 SHALL cover: store accepted at 32'h20, rst pulsed low during WAIT -> outputs reset immediately; later load 32'h20 returns the prior value, not the abandoned data.
REQ-035 SHALL cover: DM_RESP_ALIGN_CHK_EN defined, store to 32'h22 -> resp_err=1, word 32'h20 unchanged; macro undefined -> store lands in word 32'h20, resp_err=0.
REQ-036 SHALL cover: back-to-back requests with req_valid held high -> second accept occurs exactly one cycle after the first response handshake.

Source files
------------

// File: rtl/dm_responder.sv
// Single-word load/store responder with a programmable number of wait states.
// Define DM_RESP_ALIGN_CHK_EN to flag misaligned addresses through resp_err.
module dm_responder #(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic                  lat_we;
   logic                  lat_err;
   logic [DEPTH_LOG2-1:0] lat_idx;
   logic [31:0]           lat_wdata;
   logic [31:0]           mem [DEPTH];

   logic                  accept;
   logic                  in_err;
   logic                  go_resp;
   logic                  acc_we;
   logic                  acc_err;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [31:0]           acc_wdata;
   logic [31:0]           acc_rdata;
   logic                  unused_addr_bits;

   assign accept = req_valid && req_ready;

`ifdef DM_RESP_ALIGN_CHK_EN
   assign in_err = (req_addr[1:0] != 2'b00);
`else
   assign in_err = 1'b0;
`endif

   assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

   // The access happens on the edge that enters RESP: straight from IDLE when
   // there are no wait states (using the live request), else from the latch.
   always_comb begin
      go_resp   = 1'b0;
      acc_we    = lat_we;
      acc_err   = lat_err;
      acc_idx   = lat_idx;
      acc_wdata = lat_wdata;
      if (state == IDLE) begin
         acc_we    = req_we;
         acc_err   = in_err;
         acc_idx   = req_addr[DEPTH_LOG2+1:2];
         acc_wdata = req_wdata;
         go_resp   = accept && (WAIT_CYCLES == 0);
      end else if (state == WAIT) begin
         go_resp   = (cnt == 4'd1);
      end
      acc_rdata = (acc_we || acc_err) ? 32'h0 : mem[acc_idx];
   end

   // NOTE: storage has no reset so it maps onto RAM; only the control path is reset,
   // and since go_resp depends on reset state an abandoned store never commits.
   always_ff @(posedge clk) begin
      if (go_resp && acc_we && !acc_err)
         mem[acc_idx] <= acc_wdata;
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, matching the hardware regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
         lat_idx    <= '0;
         lat_wdata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  lat_we    <= req_we;
                  lat_err   <= in_err;
                  lat_idx   <= req_addr[DEPTH_LOG2+1:2];
                  lat_wdata <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= acc_rdata;
                     resp_err   <= acc_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(WAIT_CYCLES);
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (go_resp) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= acc_rdata;
                  resp_err   <= acc_err;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               req_ready  <= 1'b0;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: instance a has two wait states, instance b none.
module tb_dm_responder;

`ifdef DM_RESP_ALIGN_CHK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_resp_ready = 1'b0;
   logic [31:0] a_req_addr = 32'h0, a_req_wdata = 32'h0;
   logic        a_req_ready, a_resp_valid, a_resp_err;
   logic [31:0] a_resp_rdata;

   logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_resp_ready = 1'b0;
   logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0;
   logic        b_req_ready, b_resp_valid, b_resp_err;
   logic [31:0] b_resp_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dm_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
      .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
   );

   dm_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on instance a; lat counts cycles from accept to resp_valid.
   task automatic a_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
      int guard = 0;
      a_req_valid = 1'b1;
      a_req_we    = we;
      a_req_addr  = addr;
      a_req_wdata = wdata;
      while (!a_req_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!a_req_ready) check("a_accept_timeout", 32'(a_req_ready), 32'd1);
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      a_req_we    = ~we;
      a_req_addr  = addr ^ 32'h4;
      a_req_wdata = ~wdata;
      lat = 1;
      while (!a_resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = a_resp_rdata;
      err   = a_resp_err;
      a_resp_ready = 1'b1;
      @(posedge clk); #1;
      a_resp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;

      // Reset values while rst is low.
      #1;
      check("rst_req_ready", 32'(a_req_ready), 32'd0);
      check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
      check("rst_resp_rdata", a_resp_rdata, 32'h0);
      check("rst_resp_err", 32'(a_resp_err), 32'd0);
      #11 rst = 1'b1;
      #2 check("ready_before_first_edge", 32'(a_req_ready), 32'd0);
      @(posedge clk); #1;
      check("ready_after_first_edge", 32'(a_req_ready), 32'd1);
      check("b_ready_after_first_edge", 32'(b_req_ready), 32'd1);

      // Zero wait states: store, then load held un-acknowledged for five cycles.
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h40; b_req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      b_req_valid = 1'b0; b_req_wdata = 32'h0;
      check("b_store_valid_next", 32'(b_resp_valid), 32'd1);
      check("b_store_rdata", b_resp_rdata, 32'h0);
      b_resp_ready = 1'b1;
      @(posedge clk); #1;
      b_resp_ready = 1'b0;
      check("b_store_done_valid", 32'(b_resp_valid), 32'd0);
      check("b_ready_after_hs", 32'(b_req_ready), 32'd1);
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h40;
      @(posedge clk); #1;
      b_req_valid = 1'b0; b_req_addr = 32'h0;
      check("b_load_valid_next", 32'(b_resp_valid), 32'd1);
      check("b_load_rdata", b_resp_rdata, 32'hCAFEF00D);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("b_stall_valid", 32'(b_resp_valid), 32'd1);
         check("b_stall_rdata", b_resp_rdata, 32'hCAFEF00D);
         check("b_stall_ready", 32'(b_req_ready), 32'd0);
      end
      b_resp_ready = 1'b1;
      @(posedge clk); #1;
      b_resp_ready = 1'b0;
      check("b_load_done_valid", 32'(b_resp_valid), 32'd0);

      // Two wait states: store then load of the same word.
      a_xfer(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
      check("a_store_latency", 32'(lat), 32'd3);
      check("a_store_rdata", rd, 32'h0);
      check("a_store_err", 32'(er), 32'd0);
      a_xfer(1'b0, 32'h10, 32'h0, lat, rd, er);
      check("a_load_latency", 32'(lat), 32'd3);
      check("a_load_rdata", rd, 32'hDEADBEEF);
      check("a_load_err", 32'(er), 32'd0);

      // 64-word storage aliases every 256 bytes.
      a_xfer(1'b1, 32'h0, 32'h12345678, lat, rd, er);
      a_xfer(1'b0, 32'h100, 32'h0, lat, rd, er);
      check("alias_rdata", rd, 32'h12345678);

      // Reset during WAIT abandons the in-flight store.
      a_xfer(1'b1, 32'h20, 32'h11111111, lat, rd, er);
      a_xfer(1'b0, 32'h20, 32'h0, lat, rd, er);
      check("pre_reset_word", rd, 32'h11111111);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h55555555;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      check("mid_store_accepted", 32'(a_req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_req_ready", 32'(a_req_ready), 32'd0);
      check("mid_rst_resp_valid", 32'(a_resp_valid), 32'd0);
      check("mid_rst_resp_rdata", a_resp_rdata, 32'h0);
      check("mid_rst_resp_err", 32'(a_resp_err), 32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", 32'(a_req_ready), 32'd1);
      a_xfer(1'b0, 32'h20, 32'h0, lat, rd, er);
      check("abandoned_store", rd, 32'h11111111);

      // Misaligned store: flagged and dropped only when the check is built in.
      a_xfer(1'b1, 32'h22, 32'h99999999, lat, rd, er);
      check("misaligned_err", 32'(er), 32'(ALIGN_CHK));
      check("misaligned_rdata", rd, 32'h0);
      check("misaligned_latency", 32'(lat), 32'd3);
      a_xfer(1'b0, 32'h20, 32'h0, lat, rd, er);
      check("misaligned_word", rd, ALIGN_CHK ? 32'h11111111 : 32'h99999999);

      // Back-to-back: req_valid stays high across the first handshake.
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10;
      @(posedge clk); #1;
      check("b2b_first_accept", 32'(a_req_ready), 32'd0);
      lat = 0;
      while (!a_resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("b2b_first_rdata", a_resp_rdata, 32'hDEADBEEF);
      a_resp_ready = 1'b1;
      @(posedge clk); #1;
      a_resp_ready = 1'b0;
      check("b2b_hs_valid_low", 32'(a_resp_valid), 32'd0);
      check("b2b_no_accept_in_hs", 32'(a_req_ready), 32'd1);
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      check("b2b_second_accept", 32'(a_req_ready), 32'd0);
      lat = 1;
      while (!a_resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("b2b_second_latency", 32'(lat), 32'd3);
      check("b2b_second_rdata", a_resp_rdata, 32'hDEADBEEF);
      a_resp_ready = 1'b1;
      @(posedge clk); #1;
      a_resp_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
